// File: rtl/riscv_pkg.sv
// Shared RISC-V field types, opcode/func constants and the instruction format enum
// used by the instruction encoder slice.
package riscv_pkg;

   typedef logic [4:0] rdAdr;
   typedef logic [4:0] rsAdr;
   typedef logic [2:0] func3;
   typedef logic [6:0] func7;
   typedef logic [6:0] Opcode;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } fmt_e;

   localparam Opcode OPC_LOAD   = 7'b0000011;
   localparam Opcode OPC_FENCE  = 7'b0001111;
   localparam Opcode OPC_OP_IMM = 7'b0010011;
   localparam Opcode OPC_AUIPC  = 7'b0010111;
   localparam Opcode OPC_STORE  = 7'b0100011;
   localparam Opcode OPC_OP     = 7'b0110011;
   localparam Opcode OPC_LUI    = 7'b0110111;
   localparam Opcode OPC_BRANCH = 7'b1100011;
   localparam Opcode OPC_JALR   = 7'b1100111;
   localparam Opcode OPC_JAL    = 7'b1101111;
   localparam Opcode OPC_SYSTEM = 7'b1110011;

   localparam func3 F3_ADD_SUB   = 3'b000;
   localparam func3 F3_SLL       = 3'b001;
   localparam func3 F3_SLT       = 3'b010;
   localparam func3 F3_SLTU      = 3'b011;
   localparam func3 F3_XOR       = 3'b100;
   localparam func3 F3_SRL_SRA   = 3'b101;
   localparam func3 F3_OR        = 3'b110;
   localparam func3 F3_AND       = 3'b111;
   localparam func3 F3_SLLI      = 3'b001;
   localparam func3 F3_SRLI_SRAI = 3'b101;

   localparam func7 F7_BASE = 7'b0000000;
   localparam func7 F7_ALT  = 7'b0100000;
   localparam func7 F7_MEXT = 7'b0000001;

endpackage

// File: rtl/riscv_instr_pack.sv
// Combinational field packer and legality checker for one instruction bundle.
// Build option: define RISCV_M_EXT_EN to accept M-extension func7 on R-type.
module riscv_instr_pack
   import riscv_pkg::*;
(
   input  logic [6:0]  opcode_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [2:0]  func3_i,
   input  logic [6:0]  func7_i,
   input  logic [31:0] imm_i,
   output logic [31:0] instr_o,
   output logic        err_o
);

`ifdef RISCV_M_EXT_EN
   localparam logic M_EXT_EN = 1'b1;
`else
   localparam logic M_EXT_EN = 1'b0;
`endif

   fmt_e fmt;
   logic shift;
   logic r_func7_ok;
   logic shift_func7_ok;
   logic fits_12;
   logic fits_13;
   logic fits_21;

   // Signed range checks: all bits above the field's sign bit must match it.
   assign fits_12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
   assign fits_13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
   assign fits_21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

   assign r_func7_ok = (func7_i == F7_BASE)
                     | ((func7_i == F7_ALT) & ((func3_i == F3_ADD_SUB) | (func3_i == F3_SRL_SRA)))
                     | ((func7_i == F7_MEXT) & M_EXT_EN);

   assign shift_func7_ok = (func7_i == F7_BASE)
                         | ((func7_i == F7_ALT) & (func3_i == F3_SRLI_SRAI));

   always_comb begin
      fmt     = FMT_R;
      shift   = 1'b0;
      err_o   = 1'b0;
      instr_o = '0;

      case (opcode_i)
         OPC_OP:     fmt = FMT_R;
         OPC_OP_IMM: begin
            fmt   = FMT_I;
            shift = (func3_i == F3_SLLI) || (func3_i == F3_SRLI_SRAI);
         end
         OPC_LOAD, OPC_JALR, OPC_SYSTEM, OPC_FENCE: fmt = FMT_I;
         OPC_STORE:           fmt = FMT_S;
         OPC_BRANCH:          fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
         OPC_JAL:             fmt = FMT_J;
         default: begin
            // Unknown opcodes still go out, packed R-style, flagged as errors.
            fmt   = FMT_R;
            err_o = 1'b1;
         end
      endcase

      case (fmt)
         FMT_R: begin
            instr_o = {func7_i, rs2_i, rs1_i, func3_i, rd_i, opcode_i};
            if (opcode_i == OPC_OP) err_o = ~r_func7_ok;
         end
         FMT_I: begin
            if (shift) begin
               instr_o = {func7_i, imm_i[4:0], rs1_i, func3_i, rd_i, opcode_i};
               err_o   = (|imm_i[31:5]) | ~shift_func7_ok;
            end else begin
               instr_o = {imm_i[11:0], rs1_i, func3_i, rd_i, opcode_i};
               err_o   = ~fits_12;
            end
         end
         FMT_S: begin
            instr_o = {imm_i[11:5], rs2_i, rs1_i, func3_i, imm_i[4:0], opcode_i};
            err_o   = ~fits_12;
         end
         FMT_B: begin
            instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, func3_i,
                       imm_i[4:1], imm_i[11], opcode_i};
            err_o   = ~fits_13 | imm_i[0];
         end
         FMT_U: begin
            instr_o = {imm_i[31:12], rd_i, opcode_i};
            err_o   = |imm_i[11:0];
         end
         FMT_J: begin
            instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            err_o   = ~fits_21 | imm_i[0];
         end
         default: begin
            instr_o = '0;
            err_o   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/riscv_instr_encoder.sv
// Streaming instruction encoder: packer feeding a registered output stage with a
// one-entry skid buffer and a delivered-bundle counter.
module riscv_instr_encoder
   import riscv_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [6:0]           in_opcode,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rs1,
   input  logic [4:0]           in_rs2,
   input  logic [2:0]           in_func3,
   input  logic [6:0]           in_func7,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_instr,
   output logic                 out_err,
   output logic [CNT_WIDTH-1:0] enc_count
);

   logic [31:0]          pack_instr;
   logic                 pack_err;
   logic                 accept;
   logic                 fire;

   logic                 out_valid_q, out_valid_d;
   logic [31:0]          out_instr_q, out_instr_d;
   logic                 out_err_q,   out_err_d;
   logic                 skid_valid_q, skid_valid_d;
   logic [31:0]          skid_instr_q, skid_instr_d;
   logic                 skid_err_q,   skid_err_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   riscv_instr_pack u_pack (
      .opcode_i (in_opcode),
      .rd_i     (in_rd),
      .rs1_i    (in_rs1),
      .rs2_i    (in_rs2),
      .func3_i  (in_func3),
      .func7_i  (in_func7),
      .imm_i    (in_imm),
      .instr_o  (pack_instr),
      .err_o    (pack_err)
   );

   assign accept = in_valid & ~skid_valid_q;
   assign fire   = out_valid_q & out_ready;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_err_d    = out_err_q;
      skid_valid_d = skid_valid_q;
      skid_instr_d = skid_instr_q;
      skid_err_d   = skid_err_q;
      cnt_d        = fire ? cnt_q + CNT_WIDTH'(1) : cnt_q;

      // Output slot frees up: skid drains first to keep order, else take the new bundle.
      if (!out_valid_q || fire) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_instr_d  = skid_instr_q;
            out_err_d    = skid_err_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d  = 1'b1;
            out_instr_d  = pack_instr;
            out_err_d    = pack_err;
         end else begin
            out_valid_d  = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_instr_d = pack_instr;
         skid_err_d   = pack_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q  <= 1'b0;
         out_instr_q  <= '0;
         out_err_q    <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_instr_q <= '0;
         skid_err_q   <= 1'b0;
         cnt_q        <= '0;
      end else begin
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_err_q    <= out_err_d;
         skid_valid_q <= skid_valid_d;
         skid_instr_q <= skid_instr_d;
         skid_err_q   <= skid_err_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_err   = out_err_q;
   assign enc_count = cnt_q;

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Scoreboard bench for riscv_instr_encoder: a driver pushes expected results on
// accept, a monitor pops and compares on every output handshake.
module tb_riscv_instr_encoder;

   typedef struct {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [31:0] imm;
      logic [31:0] exp_instr;
      logic        exp_err;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [6:0]  in_opcode = '0;
   logic [4:0]  in_rd = '0;
   logic [4:0]  in_rs1 = '0;
   logic [4:0]  in_rs2 = '0;
   logic [2:0]  in_func3 = '0;
   logic [6:0]  in_func7 = '0;
   logic [31:0] in_imm = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_instr;
   logic        out_err;
   logic [3:0]  enc_count;

   stim_t stim_q[$];
   stim_t sb[$];
   int    n_vec = 0;
   int    n_err = 0;

`ifdef RISCV_M_EXT_EN
   localparam logic MUL_ERR = 1'b0;
`else
   localparam logic MUL_ERR = 1'b1;
`endif

   riscv_instr_encoder #(.CNT_WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_opcode (in_opcode),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .in_func3  (in_func3),
      .in_func7  (in_func7),
      .in_imm    (in_imm),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_err   (out_err),
      .enc_count (enc_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic stim_t mk(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] imm, input logic [31:0] ei, input logic ee);
      stim_t s;
      s.op = op; s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.f3 = f3; s.f7 = f7;
      s.imm = imm; s.exp_instr = ei; s.exp_err = ee;
      return s;
   endfunction

   // Driver: hold each bundle until in_ready is seen before an edge, then score it.
   initial begin
      stim_t cur;
      forever begin
         if (stim_q.size() == 0 || rst) begin
            in_valid = 1'b0;
         end else begin
            cur       = stim_q[0];
            in_opcode = cur.op;  in_rd  = cur.rd;  in_rs1 = cur.rs1; in_rs2 = cur.rs2;
            in_func3  = cur.f3;  in_func7 = cur.f7; in_imm = cur.imm;
            in_valid  = 1'b1;
            @(negedge clk);
            if (in_ready && !rst && stim_q.size() != 0) begin
               sb.push_back(cur);
               void'(stim_q.pop_front());
            end
         end
         @(posedge clk);
         #1;
      end
   end

   // Monitor: compare on handshake, and check stability while stalled.
   initial begin
      stim_t       e;
      logic        stalled = 1'b0;
      logic [31:0] held_instr = '0;
      logic        held_err = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stalled = 1'b0;
         end else begin
            if (stalled && out_valid) begin
               check("stall_instr_stable", out_instr, held_instr);
               check("stall_err_stable", {31'd0, out_err}, {31'd0, held_err});
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_output", 32'd1, 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("out_instr", out_instr, e.exp_instr);
                  check("out_err", {31'd0, out_err}, {31'd0, e.exp_err});
               end
            end
            stalled    = out_valid && !out_ready;
            held_instr = out_instr;
            held_err   = out_err;
         end
      end
   end

   task automatic wait_idle(input string name);
      int unsigned i;
      for (i = 0; i < 100 && (stim_q.size() != 0 || sb.size() != 0); i++) begin
         @(posedge clk);
         #2;
      end
      check(name, (stim_q.size() != 0 || sb.size() != 0) ? 32'd1 : 32'd0, 32'd0);
   endtask

   initial begin
      int unsigned i;
      #3;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_enc_count", {28'd0, enc_count}, 32'd0);
      check("reset_out_instr", out_instr, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #2;
      check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

      // ADDI x1,x2,-1: visible right after the accepting edge.
      stim_q.push_back(mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0));
      for (i = 0; i < 20 && stim_q.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      check("addi_latency_valid", {31'd0, out_valid}, 32'd1);
      check("addi_latency_instr", out_instr, 32'hFFF1_0093);

      stim_q.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, -32'sd4,       32'hFE20_8EE3, 1'b0));
      stim_q.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3,         32'h0020_8163, 1'b1));
      stim_q.push_back(mk(7'b0110011, 5'd5, 5'd6, 5'd7, 3'b000, 7'b0100000, 32'd0,   32'h4073_02B3, 1'b0));
      stim_q.push_back(mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8,         32'h0020_A423, 1'b0));
      stim_q.push_back(mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 32'h1234_52B7, 1'b0));
      stim_q.push_back(mk(7'b0110111, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5001, 32'h1234_52B7, 1'b1));
      stim_q.push_back(mk(7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2048,      32'h0010_00EF, 1'b0));
      stim_q.push_back(mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3,   32'h4031_5093, 1'b0));
      stim_q.push_back(mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b001, 7'b0100000, 32'd3,   32'h4031_1093, 1'b1));
      stim_q.push_back(mk(7'b0010011, 5'd1, 5'd2, 5'd0, 3'b000, 7'd0, 32'd2048,      32'h8001_0093, 1'b1));
      stim_q.push_back(mk(7'b1111111, 5'd0, 5'd0, 5'd0, 3'b000, 7'd0, 32'd0,         32'h0000_007F, 1'b1));
      stim_q.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4094,      32'h7E20_8FE3, 1'b0));
      stim_q.push_back(mk(7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd4096,      32'h8020_8063, 1'b1));
      stim_q.push_back(mk(7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'b0000001, 32'd0,   32'h0220_81B3, MUL_ERR));
      wait_idle("drain_batch");
      check("enc_count_15", {28'd0, enc_count}, 32'd15);

      stim_q.push_back(mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0));
      wait_idle("drain_wrap");
      check("enc_count_wrap", {28'd0, enc_count}, 32'd0);

      // Stall: three offered, only output register + skid can take them.
      out_ready = 1'b0;
      stim_q.push_back(mk(7'b0010011, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'd1, 32'h0010_0093, 1'b0));
      stim_q.push_back(mk(7'b0010011, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'd2, 32'h0020_0113, 1'b0));
      stim_q.push_back(mk(7'b0010011, 5'd3, 5'd0, 5'd0, 3'b000, 7'd0, 32'd3, 32'h0030_0193, 1'b0));
      repeat (4) @(posedge clk);
      #2;
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_accepted", (stim_q.size() == 1) ? 32'd1 : 32'd0, 32'd1);
      check("stall_head_instr", out_instr, 32'h0010_0093);
      out_ready = 1'b1;
      wait_idle("drain_stall");
      check("enc_count_3", {28'd0, enc_count}, 32'd3);

      // Reset with both entries occupied.
      out_ready = 1'b0;
      stim_q.push_back(mk(7'b0010011, 5'd4, 5'd0, 5'd0, 3'b000, 7'd0, 32'd4, 32'h0040_0213, 1'b0));
      stim_q.push_back(mk(7'b0010011, 5'd5, 5'd0, 5'd0, 3'b000, 7'd0, 32'd5, 32'h0050_0293, 1'b0));
      repeat (4) @(posedge clk);
      #2;
      check("full_in_ready", {31'd0, in_ready}, 32'd0);
      #1 rst = 1'b1;
      #1;
      check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("async_rst_enc_count", {28'd0, enc_count}, 32'd0);
      check("async_rst_out_instr", out_instr, 32'd0);
      check("async_rst_out_err", {31'd0, out_err}, 32'd0);
      stim_q.delete();
      sb.delete();
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      check("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
      repeat (3) @(posedge clk);
      #2;
      check("no_output_after_rst", {31'd0, out_valid}, 32'd0);
      stim_q.push_back(mk(7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020_A423, 1'b0));
      wait_idle("drain_post_rst");
      check("enc_count_1", {28'd0, enc_count}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
